game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter LED_DIV, default 24, log2 of the clk_d cycles per flow_led rotation step in WINNED.
REQ-002 Parameter STEP_MAX, default 63, saturation value of step_number (STEP_MAX <= 63).
REQ-003 clk_d  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start_sw  input  1  game-enable switch level; synchronous to clk_d.
REQ-006 reset_flag  input  1  one-cycle pulse requesting a board restart.
REQ-007 act_flag  input  4  one-cycle move pulses, bit index = direction code.
REQ-008 init_done  input  1  one-cycle pulse from the board datapath: board load complete.
REQ-009 move_done  input  1  one-cycle pulse from the play datapath: requested move finished.
REQ-010 move_valid  input  1  qualifies move_done: 1 = tile moved, 0 = illegal move.
REQ-011 win_flag  input  1  level from the play datapath: board is solved.
REQ-012 game_status  output  2  state code: CHOSE_BOARD 00, GAMING 01, GAME_INITIAL 10, WINNED 11.
REQ-013 load_board  output  1  one-cycle strobe commanding the board load.
REQ-014 move_req  output  1  move request, held until move_done.
REQ-015 move_dir  output  2  direction of the current request, stable while move_req=1.
REQ-016 step_number  output  6  count of valid moves in the current game.
REQ-017 flow_led  output  8  win animation pattern.

Function
REQ-018 start_sw is registered once internally; a rising edge (previous 0, current 1) is the start event.
REQ-019 CHOSE_BOARD: the start event SHALL move to GAME_INITIAL; all other inputs are ignored.
REQ-020 Entry to GAME_INITIAL SHALL assert load_board for exactly the first cycle in that state and clear step_number to 0 in the same cycle.
REQ-021 GAME_INITIAL: init_done moves to GAMING; act_flag, win_flag and move_done are ignored; start_sw=0 returns to CHOSE_BOARD.
REQ-022 GAMING, idle (move_req=0): any act_flag bit set SHALL assert move_req on the next cycle, with move_dir = index of the lowest set bit.
REQ-023 GAMING, move pending (move_req=1): act_flag is ignored; no queuing.
REQ-024 move_done SHALL drop move_req on the next cycle; if move_valid=1, step_number increments by 1, saturating at STEP_MAX.
REQ-025 A new request SHALL be accepted no earlier than the cycle after move_req drops.
REQ-026 GAMING, idle, win_flag=1 SHALL move to WINNED; win_flag has priority over a same-cycle act_flag.
REQ-027 GAMING: reset_flag or start_sw=0 arriving while a move is pending SHALL be latched and acted on in the cycle move_done is seen; that move still updates step_number per REQ-024.
REQ-028 Same-cycle priority in GAMING and WINNED, highest first: start_sw=0 (to CHOSE_BOARD), reset_flag (to GAME_INITIAL), win_flag, act_flag.
REQ-029 WINNED: step_number frozen; flow_led starts at 8'h01 and rotates left by one bit every 2^LED_DIV cycles, wrapping 8'h80 to 8'h01.
REQ-030 flow_led SHALL be 8'h00 in every state other than WINNED; its divider clears on entry to WINNED.
REQ-031 WINNED: reset_flag moves to GAME_INITIAL; start_sw=0 moves to CHOSE_BOARD.
REQ-032 move_done outside GAMING or with move_req=0 SHALL be ignored.
REQ-033 Unused state encodings are unreachable; any other register corruption is recovered by rst.

Reset
REQ-034 rst=1 at a clock edge SHALL force CHOSE_BOARD (game_status=00), load_board=0, move_req=0, move_dir=00, step_number=0, flow_led=8'h00, and clear the pending latch, the start_sw history register and the LED divider.
REQ-035 rst overrides every other input in every state, including mid-move; after rst the start_sw history reads 0, so start_sw held at 1 through reset produces a start event on the first cycle after release.

Verification
REQ-036 rst released, start_sw 0->1 -> game_status=10, load_board high for 1 cycle, step_number=0; init_done -> game_status=01.
REQ-037 GAMING, act_flag=4'b1010 -> move_req=1, move_dir=01; move_done with move_valid=1 -> move_req=0, step_number=1; repeat with move_valid=0 -> step_number stays 1.
REQ-038 70 valid moves -> step_number saturates at 63.
REQ-039 reset_flag during a pending move -> state stays 01 until move_done, then 10 with a load_board pulse and step_number=0.
REQ-040 win_flag=1 and act_flag in the same idle cycle -> game_status=11, no move_req; with LED_DIV=2, flow_led is 01, 02, 04, ... every 4 cycles, wrapping to 01 after 80.
REQ-041 WINNED, start_sw=0 and reset_flag in the same cycle -> game_status=00, flow_led=00.

Source files
------------

// File: rtl/game_sequencer.sv
// Top-level game control FSM: board selection, board load, move handshaking,
// step counting and the win animation for the sliding-tile game.
module game_sequencer #(
    parameter int LED_DIV  = 24,
    parameter int STEP_MAX = 63
) (
    input  logic       clk_d,
    input  logic       rst,
    input  logic       start_sw,
    input  logic       reset_flag,
    input  logic [3:0] act_flag,
    input  logic       init_done,
    input  logic       move_done,
    input  logic       move_valid,
    input  logic       win_flag,
    output logic [1:0] game_status,
    output logic       load_board,
    output logic       move_req,
    output logic [1:0] move_dir,
    output logic [5:0] step_number,
    output logic [7:0] flow_led
);

    typedef enum logic [1:0] {
        CHOSE_BOARD  = 2'b00,
        GAMING       = 2'b01,
        GAME_INITIAL = 2'b10,
        WINNED       = 2'b11
    } state_t;

    localparam logic [5:0] STEP_LIM = 6'(STEP_MAX);

    state_t               state;
    state_t               next_state;
    logic                 start_prev;
    logic                 pend_exit;
    logic                 pend_restart;
    logic [LED_DIV-1:0]   led_div;
    logic                 start_evt;
    logic                 accept_move;
    logic                 finish_move;

    function automatic logic [1:0] lowest_dir(input logic [3:0] flags);
        if (flags[0])      return 2'd0;
        else if (flags[1]) return 2'd1;
        else if (flags[2]) return 2'd2;
        else               return 2'd3;
    endfunction

    assign start_evt   = start_sw & ~start_prev;
    assign game_status = state;

    // Transition decisions; entry side effects are applied in the register block.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        next_state  = state;
        accept_move = 1'b0;
        finish_move = 1'b0;
        case (state)
            CHOSE_BOARD: begin
                if (start_evt) next_state = GAME_INITIAL;
            end
            GAME_INITIAL: begin
                if (!start_sw)      next_state = CHOSE_BOARD;
                else if (init_done) next_state = GAMING;
            end
            GAMING: begin
                if (move_req) begin
                    // Exit/restart requests wait for the outstanding move to finish.
                    if (move_done) begin
                        finish_move = 1'b1;
                        if (pend_exit || !start_sw)           next_state = CHOSE_BOARD;
                        else if (pend_restart || reset_flag)  next_state = GAME_INITIAL;
                    end
                end else begin
                    if (!start_sw)         next_state = CHOSE_BOARD;
                    else if (reset_flag)   next_state = GAME_INITIAL;
                    else if (win_flag)     next_state = WINNED;
                    else if (|act_flag)    accept_move = 1'b1;
                end
            end
            WINNED: begin
                if (!start_sw)       next_state = CHOSE_BOARD;
                else if (reset_flag) next_state = GAME_INITIAL;
            end
            default: next_state = CHOSE_BOARD;
        endcase
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            state        <= CHOSE_BOARD;
            start_prev   <= 1'b0;
            pend_exit    <= 1'b0;
            pend_restart <= 1'b0;
            load_board   <= 1'b0;
            move_req     <= 1'b0;
            move_dir     <= 2'd0;
            step_number  <= 6'd0;
            flow_led     <= 8'h00;
            led_div      <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; later assignments in this block override earlier ones.
            state      <= next_state;
            start_prev <= start_sw;
            load_board <= 1'b0;

            if (accept_move) begin
                move_req <= 1'b1;
                move_dir <= lowest_dir(act_flag);
            end

            if (finish_move) begin
                move_req     <= 1'b0;
                pend_exit    <= 1'b0;
                pend_restart <= 1'b0;
                if (move_valid && step_number < STEP_LIM)
                    step_number <= step_number + 6'd1;
            end else if (state == GAMING && move_req) begin
                pend_exit    <= pend_exit | ~start_sw;
                pend_restart <= pend_restart | reset_flag;
            end

            // Entering a new game clears the count, overriding a same-cycle increment.
            if (next_state == GAME_INITIAL && state != GAME_INITIAL) begin
                load_board  <= 1'b1;
                step_number <= 6'd0;
            end

            if (next_state == WINNED) begin
                if (state != WINNED) begin
                    flow_led <= 8'h01;
                    led_div  <= '0;
                end else begin
                    led_div <= led_div + 1'b1;
                    if (&led_div) flow_led <= {flow_led[6:0], flow_led[7]};
                end
            end else begin
                flow_led <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer with hand-computed expectations (LED_DIV=2).
module tb_game_sequencer;

    logic       clk_d = 1'b0;
    logic       rst;
    logic       start_sw;
    logic       reset_flag;
    logic [3:0] act_flag;
    logic       init_done;
    logic       move_done;
    logic       move_valid;
    logic       win_flag;
    logic [1:0] game_status;
    logic       load_board;
    logic       move_req;
    logic [1:0] move_dir;
    logic [5:0] step_number;
    logic [7:0] flow_led;

    int checks   = 0;
    int failures = 0;

    game_sequencer #(.LED_DIV(2), .STEP_MAX(63)) dut (
        .clk_d       (clk_d),
        .rst         (rst),
        .start_sw    (start_sw),
        .reset_flag  (reset_flag),
        .act_flag    (act_flag),
        .init_done   (init_done),
        .move_done   (move_done),
        .move_valid  (move_valid),
        .win_flag    (win_flag),
        .game_status (game_status),
        .load_board  (load_board),
        .move_req    (move_req),
        .move_dir    (move_dir),
        .step_number (step_number),
        .flow_led    (flow_led)
    );

    always #5 clk_d = ~clk_d;

    task automatic tick();
        @(posedge clk_d);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clear_pulses();
        reset_flag = 1'b0;
        act_flag   = 4'b0000;
        init_done  = 1'b0;
        move_done  = 1'b0;
        move_valid = 1'b0;
        win_flag   = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_led;
        rst = 1'b1;
        start_sw = 1'b0;
        clear_pulses();
        tick();
        tick();
        check("rst_status", {6'd0, game_status}, 8'h00);
        check("rst_load",   {7'd0, load_board},  8'h00);
        check("rst_req",    {7'd0, move_req},    8'h00);
        check("rst_dir",    {6'd0, move_dir},    8'h00);
        check("rst_step",   {2'd0, step_number}, 8'h00);
        check("rst_led",    flow_led,            8'h00);

        // Start event loads the board.
        rst = 1'b0;
        tick();
        check("idle_status", {6'd0, game_status}, 8'h00);
        start_sw = 1'b1;
        tick();
        check("init_status", {6'd0, game_status}, 8'h02);
        check("init_load",   {7'd0, load_board},  8'h01);
        check("init_step",   {2'd0, step_number}, 8'h00);
        act_flag = 4'b0001;
        tick();
        act_flag = 4'b0000;
        check("init_load_drop", {7'd0, load_board}, 8'h00);
        check("init_ignore_act", {7'd0, move_req}, 8'h00);
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        check("gaming_status", {6'd0, game_status}, 8'h01);

        // Valid move, lowest set bit picks the direction.
        act_flag = 4'b1010;
        tick();
        act_flag = 4'b0001;
        check("mv1_req", {7'd0, move_req}, 8'h01);
        check("mv1_dir", {6'd0, move_dir}, 8'h01);
        tick();
        act_flag = 4'b0000;
        check("mv1_noqueue_dir", {6'd0, move_dir}, 8'h01);
        move_done = 1'b1; move_valid = 1'b1; act_flag = 4'b0100;
        tick();
        clear_pulses();
        check("mv1_req_drop", {7'd0, move_req}, 8'h00);
        check("mv1_step",     {2'd0, step_number}, 8'h01);

        // Invalid move leaves the count unchanged.
        act_flag = 4'b0100;
        tick();
        act_flag = 4'b0000;
        check("mv2_dir", {6'd0, move_dir}, 8'h02);
        move_done = 1'b1; move_valid = 1'b0;
        tick();
        clear_pulses();
        check("mv2_req_drop", {7'd0, move_req}, 8'h00);
        check("mv2_step",     {2'd0, step_number}, 8'h01);

        // Stray move_done while idle is ignored.
        move_done = 1'b1; move_valid = 1'b1;
        tick();
        clear_pulses();
        check("stray_done_step", {2'd0, step_number}, 8'h01);

        // Saturation at STEP_MAX.
        for (int i = 0; i < 70; i++) begin
            act_flag = 4'b0001;
            tick();
            act_flag = 4'b0000;
            move_done = 1'b1; move_valid = 1'b1;
            tick();
            clear_pulses();
        end
        check("sat_step", {2'd0, step_number}, 8'd63);
        check("sat_req",  {7'd0, move_req},    8'h00);

        // Restart requested mid-move waits for move_done.
        act_flag = 4'b1000;
        tick();
        act_flag = 4'b0000;
        check("rf_dir", {6'd0, move_dir}, 8'h03);
        reset_flag = 1'b1;
        tick();
        reset_flag = 1'b0;
        check("rf_hold_status", {6'd0, game_status}, 8'h01);
        tick();
        check("rf_hold_status2", {6'd0, game_status}, 8'h01);
        move_done = 1'b1; move_valid = 1'b1;
        tick();
        clear_pulses();
        check("rf_status", {6'd0, game_status}, 8'h02);
        check("rf_load",   {7'd0, load_board},  8'h01);
        check("rf_step",   {2'd0, step_number}, 8'h00);
        check("rf_req",    {7'd0, move_req},    8'h00);
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        check("rf_gaming", {6'd0, game_status}, 8'h01);

        // Win beats a same-cycle move request; LED rotates every 4 cycles.
        win_flag = 1'b1; act_flag = 4'b0010;
        tick();
        clear_pulses();
        check("win_status", {6'd0, game_status}, 8'h03);
        check("win_req",    {7'd0, move_req},    8'h00);
        check("win_led0",   flow_led,            8'h01);
        tick(); tick(); tick();
        check("win_led0_hold", flow_led, 8'h01);
        exp_led = 8'h01;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                tick(); tick(); tick();
            end
            tick();
            exp_led = (exp_led == 8'h80) ? 8'h01 : (exp_led << 1);
            check($sformatf("win_led_step%0d", k + 1), flow_led, exp_led);
        end
        check("win_step_frozen", {2'd0, step_number}, 8'h00);

        // start_sw=0 outranks reset_flag in WINNED.
        start_sw = 1'b0; reset_flag = 1'b1;
        tick();
        clear_pulses();
        check("exit_status", {6'd0, game_status}, 8'h00);
        check("exit_led",    flow_led,            8'h00);

        // start_sw=0 mid-move is latched until move_done.
        start_sw = 1'b1;
        tick();
        check("re_init", {6'd0, game_status}, 8'h02);
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        act_flag = 4'b0001;
        tick();
        act_flag = 4'b0000;
        start_sw = 1'b0;
        tick();
        check("sw_hold_status", {6'd0, game_status}, 8'h01);
        start_sw = 1'b1;
        tick();
        check("sw_hold_status2", {6'd0, game_status}, 8'h01);
        move_done = 1'b1; move_valid = 1'b1;
        tick();
        clear_pulses();
        check("sw_exit_status", {6'd0, game_status}, 8'h00);
        check("sw_exit_step",   {2'd0, step_number}, 8'h01);
        check("sw_exit_req",    {7'd0, move_req},    8'h00);

        // rst mid-move with start_sw held high: start event right after release.
        start_sw = 1'b0;
        tick();
        start_sw = 1'b1;
        tick();
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        act_flag = 4'b0100;
        tick();
        act_flag = 4'b0000;
        check("pre_rst_req", {7'd0, move_req}, 8'h01);
        rst = 1'b1; move_done = 1'b1; move_valid = 1'b1;
        tick();
        clear_pulses();
        check("mid_rst_status", {6'd0, game_status}, 8'h00);
        check("mid_rst_req",    {7'd0, move_req},    8'h00);
        check("mid_rst_dir",    {6'd0, move_dir},    8'h00);
        check("mid_rst_step",   {2'd0, step_number}, 8'h00);
        rst = 1'b0;
        tick();
        check("post_rst_status", {6'd0, game_status}, 8'h02);
        check("post_rst_load",   {7'd0, load_board},  8'h01);
        start_sw = 1'b0;
        tick();
        check("init_abort", {6'd0, game_status}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
